frame_writer: RTL and testbench
===============================

// Module: frame_writer
// PURPOSE
//  Write end of the 160x240 framebuffer that the VGA scan-out reads. Takes the
//  TIA pixel stream (7-bit palette index + line/frame start pulses) and writes
//  each visible pixel to framebuffer address y*160+x.
//  A small FIFO absorbs write-port stalls. Frame-complete and overflow status
//  are reported to the core.
// PARAMETERS
//  H_ACTIVE    160  visible pixels per line written
//  V_ACTIVE    240  visible lines per frame written
//  H_OFFSET    0    pixels skipped at start of each line before x=0
//  V_OFFSET    0    lines skipped after frame start before y=0
//  FIFO_DEPTH  4    write FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  pix_valid    in   1   one pixel on pix_color this cycle
//  pix_color    in   7   palette index of pixel
//  pix_hsync    in   1   one-cycle pulse: start of next line
//  pix_vsync    in   1   one-cycle pulse: start of new frame
//  fb_addr      out  16  framebuffer write address (head of FIFO)
//  fb_data      out  7   framebuffer write data (head of FIFO)
//  fb_we        out  1   write request; FIFO non-empty
//  fb_ready     in   1   memory accepts the write this cycle
//  frame_done   out  1   one-cycle pulse: V_ACTIVE lines completed
//  overflow     out  1   sticky: a pixel was dropped on a full FIFO
//  frame_count  out  8   completed frames, wraps 255->0
// BEHAVIOUR
//  Reset: state WAIT_VS. Raw line/column counters 0, FIFO empty.
//   fb_we=0, fb_addr=0, fb_data=0, frame_done=0, overflow=0, frame_count=0.
//   Reset mid-operation discards all queued writes.
//  States: WAIT_VS -> (vsync) SKIP, or ACTIVE if V_OFFSET=0.
//   SKIP -> (raw line reaches V_OFFSET) ACTIVE.
//   ACTIVE -> (hsync makes y==V_ACTIVE) DONE.
//   DONE -> (vsync) SKIP/ACTIVE.
//  vsync: raw line=0, col=0, re-enter SKIP/ACTIVE from any non-reset state.
//   Wins over hsync and pix_valid in the same cycle; that pixel is ignored.
//  vsync mid-frame (ACTIVE/SKIP): frame aborted, no frame_done, no count.
//   Queued FIFO entries still drain.
//  hsync: raw line+1, col=0. Pixel arriving on the same cycle is ignored.
//  Pixels between vsync and the first hsync belong to raw line 0.
//  y = raw_line - V_OFFSET; x = col - H_OFFSET.
//  col increments on every pix_valid and saturates at 255.
//  Pixel accepted only in ACTIVE when H_OFFSET<=col<H_OFFSET+H_ACTIVE and
//   y<V_ACTIVE. All other pixels are silently discarded (no overflow).
//  Accepted pixel pushes {y*160+x, pix_color}. Multiply is exact, 16-bit result.
//   Max address 38399.
//  DONE entry: frame_done high exactly one cycle, frame_count+1.
//   Pixels ignored until vsync.
//  FIFO is show-ahead. fb_we = !empty. fb_addr/fb_data = head entry, 0 when empty.
//   Pop when fb_we && fb_ready.
//  Latency: pixel accepted at edge N into an empty FIFO gives fb_we=1 after
//   edge N; it is written at the first edge with fb_ready=1.
//  Full FIFO with no pop: pushed pixel dropped, overflow set. Only reset clears it.
//  Full FIFO with a pop in the same cycle: push accepted, no overflow.
//  Writes retire strictly in acceptance order; no entry duplicated or reordered.
// TESTING
//  1 reset; vsync; 160 pix_valid color 0x05, fb_ready=1 -> 160 writes,
//    addr 0..159, data 0x05; fb_we rises 1 cycle after 1st pixel.
//  2 full frame of 240 lines, color=line[6:0] -> last write addr 38399;
//    frame_done one pulse after 240th hsync; frame_count=1; pixels after it ignored.
//  3 fb_ready=0, 5 pixels, FIFO_DEPTH=4 -> overflow=1;
//    after fb_ready=1, exactly 4 writes, addr 0..3.
//  4 H_OFFSET=8, V_OFFSET=2: 3rd line's 9th pixel -> addr 0;
//    col>=168 and earlier lines produce no writes.
//  5 vsync after line 100 -> no frame_done, frame_count unchanged;
//    next pixel written to addr 0.
//  6 reset with 3 queued writes -> fb_we=0 next cycle, overflow=0,
//    no further writes until vsync plus pixels.

Source files
------------

// File: rtl/frame_writer.sv
// frame_writer: turns the TIA pixel stream into framebuffer writes.
// A raw line/column tracker selects the visible window. Each accepted pixel
// is queued with its linear address y*160+x in a small show-ahead FIFO.
// That FIFO feeds the framebuffer write port whenever the memory is ready.
module frame_writer #(
  parameter int H_ACTIVE   = 160,
  parameter int V_ACTIVE   = 240,
  parameter int H_OFFSET   = 0,
  parameter int V_OFFSET   = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic [6:0]  pix_color,
  input  logic        pix_hsync,
  input  logic        pix_vsync,
  output logic [15:0] fb_addr,
  output logic [6:0]  fb_data,
  output logic        fb_we,
  input  logic        fb_ready,
  output logic        frame_done,
  output logic        overflow,
  output logic [7:0]  frame_count
);

  localparam int          PTR_W       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LINE_STRIDE = 16'd160;  // framebuffer row pitch

  typedef enum logic [1:0] {
    WAIT_VS,
    SKIP,
    ACTIVE,
    DONE
  } state_t;

  // Frames with no vertical offset start writing on the very first line.
  localparam state_t START_ST = (V_OFFSET == 0) ? ACTIVE : SKIP;

  // ---------------------------------------------------------------------------
  // Raster tracking
  // ---------------------------------------------------------------------------
  state_t      state_q;
  logic [9:0]  line_q;
  logic [7:0]  col_q;
  logic        frame_done_q;
  logic [7:0]  frame_count_q;

  logic [9:0]  line_inc_w;
  logic [9:0]  y_w;
  logic [9:0]  x_w;
  logic        in_window_w;
  logic        accept_w;
  logic [15:0] pix_addr_w;

  assign line_inc_w = line_q + 10'd1;
  // Offsets are subtracted in 10 bits, so a column left of the window wraps
  // to a large value and fails the single upper-bound compare below.
  assign y_w         = line_q - 10'(V_OFFSET);
  assign x_w         = {2'b00, col_q} - 10'(H_OFFSET);
  assign in_window_w = (x_w < 10'(H_ACTIVE)) && (y_w < 10'(V_ACTIVE));
  // Sync pulses take priority, so a pixel coinciding with either is dropped.
  assign accept_w    = (state_q == ACTIVE) && pix_valid && !pix_hsync &&
                       !pix_vsync && in_window_w;
  assign pix_addr_w  = 16'(y_w) * LINE_STRIDE + 16'(x_w);

  // Frame FSM with line/column counters and registered completion status.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= WAIT_VS;
      line_q        <= '0;
      col_q         <= '0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (pix_vsync) begin
        // A new frame always restarts, aborting any unfinished one uncounted.
        state_q <= START_ST;
        line_q  <= '0;
        col_q   <= '0;
      end else if (pix_hsync) begin
        col_q <= '0;
        unique case (state_q)
          SKIP: begin
            line_q <= line_inc_w;
            if (line_inc_w == 10'(V_OFFSET)) state_q <= ACTIVE;
          end
          ACTIVE: begin
            line_q <= line_inc_w;
            if (line_inc_w - 10'(V_OFFSET) == 10'(V_ACTIVE)) begin
              state_q       <= DONE;
              frame_done_q  <= 1'b1;
              frame_count_q <= frame_count_q + 8'd1;
            end
          end
          default: ;  // line count is irrelevant outside a frame
        endcase
      end else if (pix_valid && (col_q != 8'hFF)) begin
        col_q <= col_q + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Show-ahead write FIFO
  // ---------------------------------------------------------------------------
  logic [22:0]    mem_q [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
  logic           overflow_q;

  logic           empty_w;
  logic           full_w;
  logic           pop_w;
  logic           push_w;
  logic           drop_w;
  logic [22:0]    head_w;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty_w = (wr_ptr_q == rd_ptr_q);
  assign full_w  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop_w   = !empty_w && fb_ready;
  // A pop in the same cycle frees the slot the incoming pixel needs.
  assign push_w  = accept_w && (!full_w || pop_w);
  assign drop_w  = accept_w && full_w && !pop_w;

  assign wr_ptr_d = push_w ? wr_ptr_q + (PTR_W + 1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop_w  ? rd_ptr_q + (PTR_W + 1)'(1) : rd_ptr_q;

  // FIFO pointers and sticky overflow flag; reset discards anything queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (drop_w) overflow_q <= 1'b1;
    end
  end

  // FIFO storage write: {address, colour} of each accepted pixel.
  // NOTE: storage is deliberately not reset; the pointers alone mark valid entries.
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q[PTR_W-1:0]] <= {pix_addr_w, pix_color};
  end

  assign head_w = mem_q[rd_ptr_q[PTR_W-1:0]];

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign fb_we       = !empty_w;
  assign fb_addr     = empty_w ? 16'd0 : head_w[22:7];
  assign fb_data     = empty_w ? 7'd0  : head_w[6:0];
  assign frame_done  = frame_done_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_frame_writer.sv
// tb_frame_writer: directed bench for frame_writer.
// It drives a default-window instance and an offset-window instance (H_OFFSET=8,
// V_OFFSET=2) from the same pixel stream. It logs every retired framebuffer
// write and compares against hand-derived addresses and colours.
module tb_frame_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic [6:0]  pix_color;
  logic        pix_hsync;
  logic        pix_vsync;
  logic        fb_ready;

  logic [15:0] fb_addr;
  logic [6:0]  fb_data;
  logic        fb_we;
  logic        frame_done;
  logic        overflow;
  logic [7:0]  frame_count;

  logic [15:0] off_addr;
  logic [6:0]  off_data;
  logic        off_we;
  logic        off_done;
  logic        off_ovf;
  logic [7:0]  off_count;

  typedef struct {
    logic [15:0] addr;
    logic [6:0]  data;
  } wr_t;

  wr_t wq[$];    // writes retired by dut
  wr_t wq2[$];   // writes retired by dut_off
  int  done_cnt;
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  always #5 clk = ~clk;

  frame_writer dut (
    .clk         (clk),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .pix_color   (pix_color),
    .pix_hsync   (pix_hsync),
    .pix_vsync   (pix_vsync),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .fb_ready    (fb_ready),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .frame_count (frame_count)
  );

  frame_writer #(.H_OFFSET(8), .V_OFFSET(2)) dut_off (
    .clk         (clk),
    .reset       (reset),
    .pix_valid   (pix_valid),
    .pix_color   (pix_color),
    .pix_hsync   (pix_hsync),
    .pix_vsync   (pix_vsync),
    .fb_addr     (off_addr),
    .fb_data     (off_data),
    .fb_we       (off_we),
    .fb_ready    (fb_ready),
    .frame_done  (off_done),
    .overflow    (off_ovf),
    .frame_count (off_count)
  );

  // Write log: a write retires on any edge where fb_we and fb_ready are both high.
  always @(posedge clk) begin
    if (fb_we === 1'b1 && fb_ready === 1'b1) wq.push_back('{fb_addr, fb_data});
    if (off_we === 1'b1 && fb_ready === 1'b1) wq2.push_back('{off_addr, off_data});
    if (frame_done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock of stimulus: inputs applied after a falling edge, cleared after the next.
  task automatic cyc(input logic v, input logic [6:0] c, input logic hs, input logic vs);
    pix_valid = v;
    pix_color = c;
    pix_hsync = hs;
    pix_vsync = vs;
    @(negedge clk);
    pix_valid = 1'b0;
    pix_hsync = 1'b0;
    pix_vsync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 7'd0, 1'b0, 1'b0);
  endtask

  initial begin
    int errs;
    int base_done;

    reset     = 1'b1;
    pix_valid = 1'b0;
    pix_color = 7'd0;
    pix_hsync = 1'b0;
    pix_vsync = 1'b0;
    fb_ready  = 1'b1;
    done_cnt  = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // ---- reset state ----
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_count", frame_count, 0);

    // ---- 1: one line of colour 0x05 ----
    wq.delete();
    cyc(1'b0, 7'd0, 1'b0, 1'b1);
    check("t1_we_before", fb_we, 0);
    cyc(1'b1, 7'h05, 1'b0, 1'b0);
    check("t1_we_latency", fb_we, 1);
    check("t1_head_addr", fb_addr, 0);
    for (int i = 1; i < 160; i++) cyc(1'b1, 7'h05, 1'b0, 1'b0);
    idle(4);
    check("t1_write_count", wq.size(), 160);
    errs = 0;
    foreach (wq[i]) if (wq[i].addr !== 16'(i) || wq[i].data !== 7'h05) errs++;
    check("t1_stream", errs, 0);

    // ---- 2: full frame, colour = line[6:0]; aborted frame 1 is not counted ----
    wq.delete();
    done_cnt = 0;
    cyc(1'b0, 7'd0, 1'b0, 1'b1);
    check("t2_abort_count", frame_count, 0);
    for (int l = 0; l < 240; l++) begin
      for (int x = 0; x < 160; x++) cyc(1'b1, 7'(l), 1'b0, 1'b0);
      if (l == 239) check("t2_done_early", frame_done, 0);
      cyc(1'b0, 7'd0, 1'b1, 1'b0);
    end
    check("t2_done_pulse", frame_done, 1);
    check("t2_frame_count", frame_count, 1);
    cyc(1'b1, 7'h11, 1'b0, 1'b0);
    check("t2_done_one_cycle", frame_done, 0);
    for (int i = 0; i < 9; i++) cyc(1'b1, 7'h11, 1'b0, 1'b0);
    idle(4);
    check("t2_done_total", done_cnt, 1);
    check("t2_write_count", wq.size(), 38400);
    check("t2_last_addr", wq[wq.size()-1].addr, 38399);
    check("t2_last_data", wq[wq.size()-1].data, 7'h6F);
    errs = 0;
    foreach (wq[i]) if (wq[i].addr !== 16'(i) || wq[i].data !== 7'((i / 160) % 128)) errs++;
    check("t2_stream", errs, 0);

    // ---- 4: offset window on dut_off; 170-pixel lines on both ----
    wq.delete();
    wq2.delete();
    cyc(1'b0, 7'd0, 1'b0, 1'b1);
    for (int l = 0; l < 3; l++) begin
      for (int c = 0; c < 170; c++) cyc(1'b1, 7'(c), 1'b0, 1'b0);
      if (l < 2) cyc(1'b0, 7'd0, 1'b1, 1'b0);
    end
    idle(4);
    check("t4_off_count", wq2.size(), 160);
    check("t4_off_first_addr", wq2[0].addr, 0);
    check("t4_off_first_data", wq2[0].data, 8);
    check("t4_off_last_addr", wq2[wq2.size()-1].addr, 159);
    check("t4_off_last_data", wq2[wq2.size()-1].data, 7'h27);
    errs = 0;
    foreach (wq2[i]) if (wq2[i].addr !== 16'(i) || wq2[i].data !== 7'(i + 8)) errs++;
    check("t4_off_stream", errs, 0);
    check("t4_dflt_count", wq.size(), 480);
    check("t4_dflt_last_addr", wq[wq.size()-1].addr, 479);
    check("t4_dflt_no_ovf", overflow, 0);

    // ---- 5: vsync after 100 lines aborts the frame ----
    base_done = done_cnt;
    cyc(1'b0, 7'd0, 1'b0, 1'b1);
    for (int l = 0; l < 100; l++) begin
      cyc(1'b1, 7'h22, 1'b0, 1'b0);
      cyc(1'b1, 7'h22, 1'b0, 1'b0);
      cyc(1'b0, 7'd0, 1'b1, 1'b0);
    end
    idle(4);
    wq.delete();
    cyc(1'b0, 7'd0, 1'b0, 1'b1);
    cyc(1'b1, 7'h33, 1'b0, 1'b0);
    idle(3);
    check("t5_no_done", done_cnt - base_done, 0);
    check("t5_count_kept", frame_count, 1);
    check("t5_write_count", wq.size(), 1);
    check("t5_addr", wq[0].addr, 0);
    check("t5_data", wq[0].data, 7'h33);

    // ---- 3: stalled write port overflows on the 5th pixel ----
    wq.delete();
    fb_ready = 1'b0;
    cyc(1'b0, 7'd0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) cyc(1'b1, 7'(i), 1'b0, 1'b0);
    check("t3_no_ovf_at_4", overflow, 0);
    check("t3_head_addr", fb_addr, 0);
    check("t3_head_data", fb_data, 1);
    cyc(1'b1, 7'd5, 1'b0, 1'b0);
    check("t3_ovf", overflow, 1);
    fb_ready = 1'b1;
    idle(6);
    check("t3_write_count", wq.size(), 4);
    errs = 0;
    foreach (wq[i]) if (wq[i].addr !== 16'(i) || wq[i].data !== 7'(i + 1)) errs++;
    check("t3_stream", errs, 0);
    check("t3_ovf_sticky", overflow, 1);

    // ---- 6: reset with queued writes ----
    wq.delete();
    fb_ready = 1'b0;
    cyc(1'b0, 7'd0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 7'h44, 1'b0, 1'b0);
    check("t6_queued", fb_we, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_we_cleared", fb_we, 0);
    check("t6_ovf_cleared", overflow, 0);
    check("t6_count_cleared", frame_count, 0);
    check("t6_addr_cleared", fb_addr, 0);
    fb_ready = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b1, 7'h55, 1'b0, 1'b0);
    idle(3);
    check("t6_no_writes", wq.size(), 0);

    // ---- full FIFO with a same-cycle pop accepts the push ----
    fb_ready = 1'b0;
    cyc(1'b0, 7'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b1, 7'(8'h10 + i), 1'b0, 1'b0);
    fb_ready = 1'b1;
    cyc(1'b1, 7'h14, 1'b0, 1'b0);
    check("fp_no_ovf", overflow, 0);
    idle(6);
    check("fp_write_count", wq.size(), 5);
    errs = 0;
    foreach (wq[i]) if (wq[i].addr !== 16'(i) || wq[i].data !== 7'(8'h10 + i)) errs++;
    check("fp_stream", errs, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
